// File: rtl/freq_detect.sv
`timescale 1ns/1ps
// freq_detect: scans a range of FFT bins from RAM 1, finds the bin with the
// highest power (re^2 + im^2) and reports it. After the report, the read
// address is parked on the winning bin so the beamforming stage can read it.
module freq_detect #(
    parameter logic [9:0]  BIN_LO = 10'd1,
    parameter logic [9:0]  BIN_HI = 10'd511,
    parameter logic [28:0] THRESH = 29'd4096
) (
    input  logic        clk,
    input  logic [3:0]  KEY,
    input  logic        fftdone,
    input  logic [27:0] ramq1,
    output logic [9:0]  rdaddr1,
    output logic [9:0]  maxbin,
    output logic [28:0] maxpwr,
    output logic        sigvalid,
    output logic        detectdone
);

    localparam int PIPE_DEPTH = 2;  // matches the RAM read latency

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMPLETE} state_t;

    logic rst_n;
    logic unused_keys;

    assign rst_n       = KEY[0];
    assign unused_keys = ^KEY[3:1];

    state_t      state_reg, state_next;
    logic        drain_cnt_reg, drain_cnt_next;
    logic [9:0]  addr_reg, addr_next;
    logic        start, finish;

    logic        vld_pipe_reg [PIPE_DEPTH];
    logic [9:0]  bin_pipe_reg [PIPE_DEPTH];

    logic [28:0] best_pwr_reg, best_pwr_next;
    logic [9:0]  best_bin_reg, best_bin_next;

    logic [9:0]  maxbin_reg;
    logic [28:0] maxpwr_reg;
    logic        sigvalid_reg;
    logic        detect_reg;

    logic signed [13:0] re, im;
    logic signed [27:0] re_ext, im_ext;
    logic signed [27:0] re_sq, im_sq;
    logic [28:0]        pwr;

    // Power of the sample currently on ramq1; squares are never negative,
    // so zero-extending them into the 29-bit sum is exact.
    assign re     = ramq1[27:14];
    assign im     = ramq1[13:0];
    assign re_ext = 28'(re);
    assign im_ext = 28'(im);
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;
    assign pwr    = {1'b0, re_sq} + {1'b0, im_sq};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // Next-state logic; fftdone is only honoured while idle or complete.
    always_comb begin
        state_next     = state_reg;
        start          = 1'b0;
        finish         = 1'b0;
        drain_cnt_next = 1'b0;
        case (state_reg)
            IDLE, COMPLETE: begin
                if (fftdone) begin
                    state_next = SCAN;
                    start      = 1'b1;
                end
            end
            SCAN: begin
                if (addr_reg == BIN_HI) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                drain_cnt_next = ~drain_cnt_reg;
                if (drain_cnt_reg) begin
                    state_next = COMPLETE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Valid/bin-index pipeline that follows each issued address through the
    // two-cycle RAM read so the index lines up with its data on ramq1.
    generate
        for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                // First stage captures the address issued this cycle.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        vld_pipe_reg[gi] <= 1'b0;
                        bin_pipe_reg[gi] <= 10'd0;
                    end else begin
                        vld_pipe_reg[gi] <= (state_reg == SCAN);
                        bin_pipe_reg[gi] <= addr_reg;
                    end
                end
            end else begin : g_tail
                // Later stages shift the previous stage along.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        vld_pipe_reg[gi] <= 1'b0;
                        bin_pipe_reg[gi] <= 10'd0;
                    end else begin
                        vld_pipe_reg[gi] <= vld_pipe_reg[gi-1];
                        bin_pipe_reg[gi] <= bin_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Running maximum; strict compare keeps the lowest bin on ties.
    always_comb begin
        best_pwr_next = best_pwr_reg;
        best_bin_next = best_bin_reg;
        if (start) begin
            best_pwr_next = 29'd0;
            best_bin_next = BIN_LO;
        end else if (vld_pipe_reg[PIPE_DEPTH-1] && (pwr > best_pwr_reg)) begin
            best_pwr_next = pwr;
            best_bin_next = bin_pipe_reg[PIPE_DEPTH-1];
        end
    end

    // Read address: sweep during SCAN, then park on the winning bin.
    always_comb begin
        addr_next = addr_reg;
        if (start) begin
            addr_next = BIN_LO;
        end else if (finish) begin
            addr_next = best_bin_next;
        end else if ((state_reg == SCAN) && (addr_reg != BIN_HI)) begin
            addr_next = addr_reg + 10'd1;
        end
    end

    // Working registers and read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_pwr_reg <= 29'd0;
            best_bin_reg <= 10'd0;
            addr_reg     <= 10'd0;
        end else begin
            best_pwr_reg <= best_pwr_next;
            best_bin_reg <= best_bin_next;
            addr_reg     <= addr_next;
        end
    end

    // Result registers; they take the final compare result on the way into
    // COMPLETE, so the last sample is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maxbin_reg   <= 10'd0;
            maxpwr_reg   <= 29'd0;
            sigvalid_reg <= 1'b0;
            detect_reg   <= 1'b0;
        end else begin
            detect_reg <= finish;
            if (finish) begin
                maxbin_reg   <= best_bin_next;
                maxpwr_reg   <= best_pwr_next;
                sigvalid_reg <= (best_pwr_next >= THRESH);
            end
        end
    end

    assign rdaddr1    = addr_reg;
    assign maxbin     = maxbin_reg;
    assign maxpwr     = maxpwr_reg;
    assign sigvalid   = sigvalid_reg;
    assign detectdone = detect_reg;

endmodule

// File: tb/tb_freq_detect.sv
`timescale 1ns/1ps
// Testbench for freq_detect: RAM model with 2-cycle read latency, directed
// frames, and a scoreboard queue drained by a detectdone monitor.
module tb_freq_detect;

    logic        clk;
    logic [3:0]  KEY;
    logic        fftdone;
    logic [27:0] ramq1;
    logic [9:0]  rdaddr1;
    logic [9:0]  maxbin;
    logic [28:0] maxpwr;
    logic        sigvalid;
    logic        detectdone;

    freq_detect dut (
        .clk        (clk),
        .KEY        (KEY),
        .fftdone    (fftdone),
        .ramq1      (ramq1),
        .rdaddr1    (rdaddr1),
        .maxbin     (maxbin),
        .maxpwr     (maxpwr),
        .sigvalid   (sigvalid),
        .detectdone (detectdone)
    );

    typedef struct {
        logic [9:0]  bin;
        logic [28:0] pwr;
        logic        sv;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    logic [27:0] mem [0:1023];
    logic [27:0] ram_q1;
    int          pcount;
    int          n_chk;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, one count per rising edge.
    always @(posedge clk) pcount <= pcount + 1;

    // RAM 1 model: two register stages between address and data.
    always @(posedge clk) begin
        ram_q1 <= mem[rdaddr1];
        ramq1  <= ram_q1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every detectdone pops one expected result and compares it.
    always @(negedge clk) begin
        if (detectdone) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_detectdone: got maxbin %0d maxpwr %0d, expected no pulse (cycle %0d)",
                         maxbin, maxpwr, pcount);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("detect cycle=%0d maxbin=%0d maxpwr=%0d sigvalid=%0b", pcount, maxbin, maxpwr, sigvalid);
                chk("maxbin",   32'(maxbin),   32'(e.bin));
                chk("maxpwr",   32'(maxpwr),   32'(e.pwr));
                chk("sigvalid", 32'(sigvalid), 32'(e.sv));
                chk("latency",  32'(pcount),   32'(e.cyc));
            end
        end
    end

    task automatic fill_all(input logic signed [13:0] re, input logic signed [13:0] im);
        for (int i = 0; i < 1024; i++) mem[i] = {re, im};
    endtask

    task automatic set_bin(input int idx, input logic signed [13:0] re, input logic signed [13:0] im);
        mem[idx] = {re, im};
    endtask

    // One-cycle fftdone; returns the counter value of the sampling edge.
    task automatic pulse_fft(output int p0);
        @(negedge clk);
        fftdone = 1'b1;
        @(negedge clk);
        fftdone = 1'b0;
        p0 = pcount;
    endtask

    task automatic start_frame(input logic [9:0] eb, input logic [28:0] ep, input logic es);
        int   p0;
        exp_t e;
        pulse_fft(p0);
        e.bin = eb;
        e.pwr = ep;
        e.sv  = es;
        e.cyc = p0 + 513;
        sb.push_back(e);
        chk("rdaddr_first", 32'(rdaddr1), 32'd1);
    endtask

    task automatic wait_done(input logic [9:0] eb);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 700) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout_pending", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("rdaddr_hold", 32'(rdaddr1), 32'(eb));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdaddr1"},    32'(rdaddr1),    32'd0);
        chk({tag, "_maxbin"},     32'(maxbin),     32'd0);
        chk({tag, "_maxpwr"},     32'(maxpwr),     32'd0);
        chk({tag, "_sigvalid"},   32'(sigvalid),   32'd0);
        chk({tag, "_detectdone"}, 32'(detectdone), 32'd0);
    endtask

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int p0;
        pcount  = 0;
        n_chk   = 0;
        n_fail  = 0;
        KEY     = 4'b1110;
        fftdone = 1'b0;
        fill_all(14'sd0, 14'sd0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        KEY = 4'b1111;
        repeat (5) @(negedge clk);
        chk("idle_rdaddr", 32'(rdaddr1), 32'd0);

        // Single tone at bin 37.
        fill_all(14'sd10, -14'sd10);
        set_bin(37, 14'sd1000, 14'sd0);
        start_frame(10'd37, 29'd1000000, 1'b1);
        wait_done(10'd37);

        // Back-to-back: tie at 100/200, huge DC bin excluded; old result held.
        fill_all(14'sd0, 14'sd0);
        set_bin(100, -14'sd300, 14'sd400);
        set_bin(200, -14'sd300, 14'sd400);
        set_bin(0, 14'sd8191, 14'sd8191);
        start_frame(10'd100, 29'd250000, 1'b1);
        repeat (50) @(negedge clk);
        chk("hold_maxbin",   32'(maxbin),   32'd37);
        chk("hold_maxpwr",   32'(maxpwr),   32'd1000000);
        chk("hold_sigvalid", 32'(sigvalid), 32'd1);
        wait_done(10'd100);

        // Extreme value at the top bin.
        fill_all(14'sd0, 14'sd0);
        set_bin(511, -14'sd8192, -14'sd8192);
        start_frame(10'd511, 29'd134217728, 1'b1);
        wait_done(10'd511);

        // Extreme value at the lowest scanned bin.
        fill_all(14'sd0, 14'sd0);
        set_bin(1, -14'sd8192, -14'sd8192);
        start_frame(10'd1, 29'd134217728, 1'b1);
        wait_done(10'd1);

        // Empty frame.
        fill_all(14'sd0, 14'sd0);
        start_frame(10'd1, 29'd0, 1'b0);
        wait_done(10'd1);

        // Threshold edges: exactly 4096, then 4050.
        set_bin(300, 14'sd64, 14'sd0);
        start_frame(10'd300, 29'd4096, 1'b1);
        wait_done(10'd300);
        set_bin(300, 14'sd45, 14'sd45);
        start_frame(10'd300, 29'd4050, 1'b0);
        wait_done(10'd300);

        // fftdone re-pulsed mid-scan is ignored.
        fill_all(14'sd10, -14'sd10);
        set_bin(37, 14'sd1000, 14'sd0);
        start_frame(10'd37, 29'd1000000, 1'b1);
        repeat (98) @(negedge clk);
        fftdone = 1'b1;
        @(negedge clk);
        fftdone = 1'b0;
        wait_done(10'd37);

        // Reset mid-scan aborts the frame; restart afterwards.
        fill_all(14'sd0, 14'sd0);
        set_bin(5, 14'sd100, 14'sd0);
        pulse_fft(p0);
        repeat (198) @(negedge clk);
        KEY = 4'b1110;
        #1;
        chk_all_zero("midreset");
        repeat (3) @(negedge clk);
        KEY = 4'b1111;
        repeat (600) @(negedge clk);
        chk("post_abort_rdaddr", 32'(rdaddr1), 32'd0);
        start_frame(10'd5, 29'd10000, 1'b1);
        wait_done(10'd5);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
